// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Purpose:
//   Sits between the instruction decoder and the execute stage. Holds one
//   decoded instruction in an issue register and tracks pending writes to the
//   scalar (S) and predicate (P) register banks. The held instruction is
//   released to execute only when none of its source operands or its
//   destination has a pending write (RAW / WAW hazards). A HALT instruction,
//   once issued, drains all pending writes before the core reports halted.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  decoder handshake; in_* fields captured on acceptance
//   in_a_sel        A operand bank (0 = scalar, 1 = predicate)
//   in_a_from_rb    A operand is read from the register bank
//   in_a_addr       A operand address
//   in_b_from_rb    B operand is read from the scalar bank
//   in_b_addr       B operand address
//   in_z_sel        destination bank
//   in_z_writes     instruction writes a destination
//   in_z_addr       destination address
//   in_halt         instruction is HALT
//   out_valid/ready execute handshake; fire = out_valid && out_ready
//   wb_valid/sel/addr  writeback completion, clears a pending-write bit
//   flush           discard the held instruction (branch redirect)
//   halted          core halted (terminal until reset)
//   busy_s, busy_p  registered pending-write bits per bank
//   stall_cnt       saturating count of cycles held behind a hazard
//
// Predicate addresses use only the low bits of the address field.
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int NUM_SREGS   = 32,
  parameter int NUM_PREGS   = 8,
  parameter int REG_SEL     = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_a_sel,
  input  logic                   in_a_from_rb,
  input  logic [REG_SEL-1:0]     in_a_addr,
  input  logic                   in_b_from_rb,
  input  logic [REG_SEL-1:0]     in_b_addr,
  input  logic                   in_z_sel,
  input  logic                   in_z_writes,
  input  logic [REG_SEL-1:0]     in_z_addr,
  input  logic                   in_halt,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   wb_valid,
  input  logic                   wb_sel,
  input  logic [REG_SEL-1:0]     wb_addr,
  input  logic                   flush,
  output logic                   halted,
  output logic [NUM_SREGS-1:0]   busy_s,
  output logic [NUM_PREGS-1:0]   busy_p,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int P_SEL = $clog2(NUM_PREGS);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t state_reg, state_next;

  // Issue register
  logic               held_reg, held_next;
  logic               a_sel_reg;
  logic               a_from_rb_reg;
  logic [REG_SEL-1:0] a_addr_reg;
  logic               b_from_rb_reg;
  logic [REG_SEL-1:0] b_addr_reg;
  logic               z_sel_reg;
  logic               z_writes_reg;
  logic [REG_SEL-1:0] z_addr_reg;
  logic               halt_reg;

  // Scoreboard
  logic [NUM_SREGS-1:0] busy_s_reg, busy_s_next, wb_clr_s, set_s, eff_busy_s;
  logic [NUM_PREGS-1:0] busy_p_reg, busy_p_next, wb_clr_p, set_p, eff_busy_p;

  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic accept;
  logic fire;
  logic hazard;
  logic a_busy;
  logic b_busy;
  logic z_busy;

  // ---------------------------------------------------------------------------
  // Per-register busy bookkeeping. A writeback hides its target bit in the
  // same cycle (eff_busy), and a set from an issuing write overrides a clear
  // of the same bit so the new pending write is never lost.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SREGS; gi++) begin : g_sreg
      assign wb_clr_s[gi]    = wb_valid && !wb_sel && (wb_addr == REG_SEL'(gi));
      assign set_s[gi]       = fire && z_writes_reg && !z_sel_reg &&
                               (z_addr_reg == REG_SEL'(gi));
      assign eff_busy_s[gi]  = busy_s_reg[gi] && !wb_clr_s[gi];
      assign busy_s_next[gi] = set_s[gi] || eff_busy_s[gi];
    end
    for (gi = 0; gi < NUM_PREGS; gi++) begin : g_preg
      assign wb_clr_p[gi]    = wb_valid && wb_sel &&
                               (wb_addr[P_SEL-1:0] == P_SEL'(gi));
      assign set_p[gi]       = fire && z_writes_reg && z_sel_reg &&
                               (z_addr_reg[P_SEL-1:0] == P_SEL'(gi));
      assign eff_busy_p[gi]  = busy_p_reg[gi] && !wb_clr_p[gi];
      assign busy_p_next[gi] = set_p[gi] || eff_busy_p[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Hazard detection against the effective (writeback-adjusted) busy bits
  // ---------------------------------------------------------------------------
  always_comb begin
    a_busy = 1'b0;
    z_busy = 1'b0;
    if (a_sel_reg) a_busy = eff_busy_p[a_addr_reg[P_SEL-1:0]];
    else           a_busy = eff_busy_s[a_addr_reg];
    if (z_sel_reg) z_busy = eff_busy_p[z_addr_reg[P_SEL-1:0]];
    else           z_busy = eff_busy_s[z_addr_reg];
    b_busy = eff_busy_s[b_addr_reg];
  end

  assign hazard = (a_from_rb_reg && a_busy) ||
                  (b_from_rb_reg && b_busy) ||
                  (z_writes_reg  && z_busy);

  assign out_valid = held_reg && !hazard && (state_reg == ST_RUN);
  assign fire      = out_valid && out_ready;

  // The slot frees up in the same cycle it issues, so back-to-back accepts
  // sustain one instruction per cycle. Flush blocks capture outright.
  assign in_ready  = (state_reg == ST_RUN) && !flush && (!held_reg || fire);
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (fire && halt_reg) state_next = ST_DRAIN;
      // Drain decision uses the registered bits: halted lags the final
      // writeback by one cycle.
      ST_DRAIN:  if ((busy_s_reg == '0) && (busy_p_reg == '0)) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    held_next = held_reg;
    if (fire)   held_next = 1'b0;
    if (accept) held_next = 1'b1;
    // Flush wins over everything except in the terminal state, where it is
    // ignored.
    if (flush && (state_reg != ST_HALTED)) held_next = 1'b0;
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if ((state_reg == ST_RUN) && held_reg && hazard && (stall_cnt_reg != '1))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      held_reg      <= 1'b0;
      busy_s_reg    <= '0;
      busy_p_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      held_reg      <= held_next;
      busy_s_reg    <= busy_s_next;
      busy_p_reg    <= busy_p_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sel_reg     <= 1'b0;
      a_from_rb_reg <= 1'b0;
      a_addr_reg    <= '0;
      b_from_rb_reg <= 1'b0;
      b_addr_reg    <= '0;
      z_sel_reg     <= 1'b0;
      z_writes_reg  <= 1'b0;
      z_addr_reg    <= '0;
      halt_reg      <= 1'b0;
    end else if (accept) begin
      a_sel_reg     <= in_a_sel;
      a_from_rb_reg <= in_a_from_rb;
      a_addr_reg    <= in_a_addr;
      b_from_rb_reg <= in_b_from_rb;
      b_addr_reg    <= in_b_addr;
      z_sel_reg     <= in_z_sel;
      z_writes_reg  <= in_z_writes;
      z_addr_reg    <= in_z_addr;
      halt_reg      <= in_halt;
    end
  end

  assign halted    = (state_reg == ST_HALTED);
  assign busy_s    = busy_s_reg;
  assign busy_p    = busy_p_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
